// File: rtl/fmc_pkg.sv
// fmc_pkg: shared types and helpers for the frequency-lock controller.
//   fmc_state_e : controller FSM states
//   sat_inc     : increment clamped at a caller-supplied maximum
//   sat_dec     : decrement clamped at zero
//   win_len     : measurement window length in reference cycles (M << sh)
package fmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    EVAL = 2'd2
  } fmc_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] max);
    return (v >= max) ? max : v + 16'd1;
  endfunction

  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

  function automatic logic [31:0] win_len(input logic [15:0] m, input int unsigned sh);
    return 32'(m) << sh;
  endfunction

endpackage

// File: rtl/fmc_lock_ctrl_if.sv
// fmc_lock_ctrl_if: control/status bundle of the frequency-lock controller.
//   en, M, N, fb_div          : run enable, window multiplier, target count,
//                               asynchronous divided feedback (master -> slave)
//   sel, up, dn, lock,
//   meas_cnt, meas_valid      : delay select, step pulses, lock flag,
//                               last window count and its update strobe
interface fmc_lock_ctrl_if #(
  parameter int unsigned MW   = 4,
  parameter int unsigned NW   = 6,
  parameter int unsigned SELW = 3
);
  logic            en;
  logic [MW-1:0]   M;
  logic [NW-1:0]   N;
  logic            fb_div;
  logic [SELW-1:0] sel;
  logic            up;
  logic            dn;
  logic            lock;
  logic [NW:0]     meas_cnt;
  logic            meas_valid;

  modport master (
    output en, M, N, fb_div,
    input  sel, up, dn, lock, meas_cnt, meas_valid
  );

  modport slave (
    input  en, M, N, fb_div,
    output sel, up, dn, lock, meas_cnt, meas_valid
  );
endinterface

// File: rtl/fmc_edge_sync.sv
// fmc_edge_sync: multi-flop synchroniser followed by a rising-edge detector.
//   clk, rst_n : clock, synchronous active-low reset
//   async_in   : asynchronous input
//   rise_pulse : one-cycle pulse in the cycle the synchronised input first reads 1
module fmc_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    // shift in at bit 0; the cast drops the bit shifted out of the top
    sync_d = STAGES'({sync_q, async_in});
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/fmc_lock_ctrl.sv
// fmc_lock_ctrl: windowed feedback edge counter with saturating delay-select
// stepping and lock detection. Single clock domain (clk_ext).
//   clk_ext : reference clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of fmc_lock_ctrl_if (en/M/N/fb_div in,
//             sel/up/dn/lock/meas_cnt/meas_valid out)
module fmc_lock_ctrl
  import fmc_pkg::*;
#(
  parameter int unsigned MW       = 4,
  parameter int unsigned NW       = 6,
  parameter int unsigned SELW     = 3,
  parameter int unsigned WIN_SH   = 2,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned SEL_INIT = 4
) (
  input  logic           clk_ext,
  input  logic           rst_n,
  fmc_lock_ctrl_if.slave bus
);

  localparam int unsigned WW  = MW + WIN_SH;
  localparam int unsigned LCW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [SELW-1:0] SEL_MAX = '1;
  localparam logic [NW:0]     CNT_MAX = '1;

  fmc_state_e      state_q, state_d;
  logic [MW-1:0]   m_q, m_d;
  logic [NW-1:0]   n_q, n_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [NW:0]     cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            up_q, up_d;
  logic            dn_q, dn_d;
  logic            lock_q, lock_d;
  logic [LCW-1:0]  lcnt_q, lcnt_d;
  logic [NW:0]     meas_cnt_q, meas_cnt_d;
  logic            meas_valid_q, meas_valid_d;

  logic            fb_rise;
  logic            go;
  logic            cfg_changed;
  logic [WW-1:0]   wlen;
  logic signed [NW+1:0] cnt_s, hi_s, lo_s;

  fmc_edge_sync #(.STAGES(2)) u_edge_sync (
    .clk        (clk_ext),
    .rst_n      (rst_n),
    .async_in   (bus.fb_div),
    .rise_pulse (fb_rise)
  );

  assign go          = bus.en && (bus.M != '0);
  assign cfg_changed = (bus.M != m_q) || (bus.N != n_q);
  assign wlen        = WW'(win_len(16'(m_q), WIN_SH));

  // one extra bit of headroom so N - TOL cannot wrap below zero
  assign cnt_s = $signed({1'b0, cnt_q});
  assign hi_s  = $signed({2'b00, n_q}) + $signed((NW+2)'(TOL));
  assign lo_s  = $signed({2'b00, n_q}) - $signed((NW+2)'(TOL));

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    wcnt_d       = wcnt_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    up_d         = 1'b0;
    dn_d         = 1'b0;
    lock_d       = lock_q;
    lcnt_d       = lcnt_q;
    meas_cnt_d   = meas_cnt_q;
    meas_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        cnt_d  = '0;
        lcnt_d = '0;
        lock_d = 1'b0;
        if (go) begin
          state_d = MEAS;
          m_d     = bus.M;
          n_d     = bus.N;
        end
      end

      MEAS: begin
        if (!go) begin
          state_d = IDLE;
          wcnt_d  = '0;
          cnt_d   = '0;
          lcnt_d  = '0;
          lock_d  = 1'b0;
        end else if (cfg_changed) begin
          // abort outranks the window end: restart with the new settings
          m_d    = bus.M;
          n_d    = bus.N;
          wcnt_d = '0;
          cnt_d  = '0;
          lcnt_d = '0;
          lock_d = 1'b0;
        end else begin
          if (fb_rise) begin
            cnt_d = (NW+1)'(sat_inc(16'(cnt_q), 16'(CNT_MAX)));
          end
          if (wcnt_q == wlen - WW'(1)) begin
            state_d = EVAL;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end

      EVAL: begin
        if (!go) begin
          state_d = IDLE;
          wcnt_d  = '0;
          cnt_d   = '0;
          lcnt_d  = '0;
          lock_d  = 1'b0;
        end else begin
          state_d      = MEAS;
          m_d          = bus.M;
          n_d          = bus.N;
          wcnt_d       = '0;
          cnt_d        = '0;
          meas_cnt_d   = cnt_q;
          meas_valid_d = 1'b1;
          if (cnt_s > hi_s) begin
            if (sel_q != SEL_MAX) begin
              sel_d = SELW'(sat_inc(16'(sel_q), 16'(SEL_MAX)));
              up_d  = 1'b1;
            end
            lcnt_d = '0;
            lock_d = 1'b0;
          end else if (cnt_s < lo_s) begin
            if (sel_q != '0) begin
              sel_d = SELW'(sat_dec(16'(sel_q)));
              dn_d  = 1'b1;
            end
            lcnt_d = '0;
            lock_d = 1'b0;
          end else begin
            lcnt_d = LCW'(sat_inc(16'(lcnt_q), 16'(LOCK_CNT)));
            lock_d = (lcnt_d == LCW'(LOCK_CNT));
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ext) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_q          <= '0;
      n_q          <= '0;
      wcnt_q       <= '0;
      cnt_q        <= '0;
      sel_q        <= SELW'(SEL_INIT);
      up_q         <= 1'b0;
      dn_q         <= 1'b0;
      lock_q       <= 1'b0;
      lcnt_q       <= '0;
      meas_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      n_q          <= n_d;
      wcnt_q       <= wcnt_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      up_q         <= up_d;
      dn_q         <= dn_d;
      lock_q       <= lock_d;
      lcnt_q       <= lcnt_d;
      meas_cnt_q   <= meas_cnt_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.up         = up_q;
  assign bus.dn         = dn_q;
  assign bus.lock       = lock_q;
  assign bus.meas_cnt   = meas_cnt_q;
  assign bus.meas_valid = meas_valid_q;

endmodule
